ws2812_bit_sequencer: RTL and testbench



---
 rtl/ws2812_bit_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_ws2812_bit_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_bit_sequencer.sv
// WS2812 bit sequencer: shifts 24-bit GRB words MSB first onto the LED data
// line, timing every line phase with an external one-shot reload timer.
module ws2812_bit_sequencer #(
  parameter int VALUE_BIT_SIZE = 10,
  parameter int T0H            = 16,
  parameter int T0L            = 34,
  parameter int T1H            = 32,
  parameter int T1L            = 18,
  parameter int TRESET         = 1000
) (
  input  logic                      Clock,
  input  logic                      cRst,
  input  logic [23:0]               Pixel_Data,
  input  logic                      Pixel_Last,
  input  logic                      Pixel_Valid,
  output logic                      Pixel_Ready,
  output logic                      Timer_Reload,
  output logic [VALUE_BIT_SIZE-1:0] Timer_Value,
  input  logic                      Timer_Done,
  output logic                      Dout,
  output logic                      Busy,
  output logic                      Underrun,
  output logic                      Frame_Done
);

  // A phase of T cycles is programmed as T-2, so every phase must be >= 3
  // and T-2 must fit in the reload field.
  localparam int VMAX = (1 << VALUE_BIT_SIZE) - 1;

  generate
    if (T0H < 3 || T0L < 3 || T1H < 3 || T1L < 3 || TRESET < 3) begin : g_bad_timing
      $error("ws2812_bit_sequencer: every timing parameter must be at least 3");
    end
    if (T0H - 2 > VMAX || T0L - 2 > VMAX || T1H - 2 > VMAX ||
        T1L - 2 > VMAX || TRESET - 2 > VMAX) begin : g_bad_width
      $error("ws2812_bit_sequencer: timing parameter does not fit VALUE_BIT_SIZE");
    end
  endgenerate

  localparam logic [VALUE_BIT_SIZE-1:0] V_T0H = VALUE_BIT_SIZE'(T0H - 2);
  localparam logic [VALUE_BIT_SIZE-1:0] V_T0L = VALUE_BIT_SIZE'(T0L - 2);
  localparam logic [VALUE_BIT_SIZE-1:0] V_T1H = VALUE_BIT_SIZE'(T1H - 2);
  localparam logic [VALUE_BIT_SIZE-1:0] V_T1L = VALUE_BIT_SIZE'(T1L - 2);
  localparam logic [VALUE_BIT_SIZE-1:0] V_RST = VALUE_BIT_SIZE'(TRESET - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_WAIT,
    S_LATCH
  } state_t;

  state_t                      state, state_nxt;
  logic [23:0]                 shift_q;
  logic                        last_q;
  logic [4:0]                  bit_cnt;

  logic                        done_ok;
  logic                        accept;
  logic                        shift_en;
  logic                        dout_nxt;
  logic                        reload_nxt;
  logic [VALUE_BIT_SIZE-1:0]   value_nxt;
  logic                        underrun_nxt;
  logic                        frame_done_nxt;

  function automatic logic [VALUE_BIT_SIZE-1:0] hi_val(input logic b);
    return b ? V_T1H : V_T0H;
  endfunction

  function automatic logic [VALUE_BIT_SIZE-1:0] lo_val(input logic b);
    return b ? V_T1L : V_T0L;
  endfunction

  // The timer still shows the previous phase's timeout while the reload
  // strobe is out, so Done only counts once the strobe has dropped.
  assign done_ok = Timer_Done & ~Timer_Reload;
  assign accept  = Pixel_Ready & Pixel_Valid;
  assign Busy    = (state != S_IDLE);

  // Ready: open between frames, and in the final LOW cycle of a non-last
  // pixel so the next word chains on without a gap.
  always_comb begin
    Pixel_Ready = 1'b0;
    case (state)
      S_IDLE, S_WAIT: Pixel_Ready = 1'b1;
      S_LOW:          Pixel_Ready = done_ok && (bit_cnt == 5'd0) && !last_q;
      default:        Pixel_Ready = 1'b0;
    endcase
  end

  // Next-state and next-output decode; one reload per phase transition.
  always_comb begin
    state_nxt      = state;
    shift_en       = 1'b0;
    dout_nxt       = Dout;
    reload_nxt     = 1'b0;
    value_nxt      = Timer_Value;
    underrun_nxt   = 1'b0;
    frame_done_nxt = 1'b0;
    case (state)
      S_IDLE, S_WAIT: begin
        if (accept) begin
          state_nxt  = S_HIGH;
          dout_nxt   = 1'b1;
          reload_nxt = 1'b1;
          value_nxt  = hi_val(Pixel_Data[23]);
        end
      end
      S_HIGH: begin
        if (done_ok) begin
          state_nxt  = S_LOW;
          dout_nxt   = 1'b0;
          reload_nxt = 1'b1;
          value_nxt  = lo_val(shift_q[23]);
        end
      end
      S_LOW: begin
        if (done_ok) begin
          if (bit_cnt != 5'd0) begin
            state_nxt  = S_HIGH;
            shift_en   = 1'b1;
            dout_nxt   = 1'b1;
            reload_nxt = 1'b1;
            value_nxt  = hi_val(shift_q[22]);
          end else if (last_q) begin
            state_nxt  = S_LATCH;
            reload_nxt = 1'b1;
            value_nxt  = V_RST;
          end else if (accept) begin
            state_nxt  = S_HIGH;
            dout_nxt   = 1'b1;
            reload_nxt = 1'b1;
            value_nxt  = hi_val(Pixel_Data[23]);
          end else begin
            state_nxt    = S_WAIT;
            dout_nxt     = 1'b0;
            underrun_nxt = 1'b1;
          end
        end
      end
      S_LATCH: begin
        if (done_ok) begin
          state_nxt      = S_IDLE;
          frame_done_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State and registered line/timer outputs.
  always_ff @(posedge Clock) begin
    if (cRst) begin
      state        <= S_IDLE;
      Dout         <= 1'b0;
      Timer_Reload <= 1'b0;
      Timer_Value  <= '0;
      Underrun     <= 1'b0;
      Frame_Done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      Dout         <= dout_nxt;
      Timer_Reload <= reload_nxt;
      Timer_Value  <= value_nxt;
      Underrun     <= underrun_nxt;
      Frame_Done   <= frame_done_nxt;
    end
  end

  // Pixel shift register: load on handshake, shift left after each bit.
  always_ff @(posedge Clock) begin
    if (cRst) begin
      shift_q <= '0;
      last_q  <= 1'b0;
      bit_cnt <= '0;
    end else if (accept) begin
      shift_q <= Pixel_Data;
      last_q  <= Pixel_Last;
      bit_cnt <= 5'd23;
    end else if (shift_en) begin
      shift_q <= {shift_q[22:0], 1'b0};
      bit_cnt <= bit_cnt - 5'd1;
    end
  end

endmodule

// File: tb/tb_ws2812_bit_sequencer.sv
// Directed bench for ws2812_bit_sequencer with a one-shot reload timer model.
module tb_ws2812_bit_sequencer;
  localparam int VW  = 10;
  localparam int T0H = 4;
  localparam int T0L = 8;
  localparam int T1H = 8;
  localparam int T1L = 4;
  localparam int TR  = 20;

  logic          Clock = 1'b0;
  logic          cRst  = 1'b1;
  logic [23:0]   Pixel_Data  = '0;
  logic          Pixel_Last  = 1'b0;
  logic          Pixel_Valid = 1'b0;
  logic          Pixel_Ready;
  logic          Timer_Reload;
  logic [VW-1:0] Timer_Value;
  logic          Timer_Done;
  logic          Dout;
  logic          Busy;
  logic          Underrun;
  logic          Frame_Done;

  ws2812_bit_sequencer #(
    .VALUE_BIT_SIZE(VW), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L), .TRESET(TR)
  ) dut (
    .Clock(Clock), .cRst(cRst), .Pixel_Data(Pixel_Data), .Pixel_Last(Pixel_Last),
    .Pixel_Valid(Pixel_Valid), .Pixel_Ready(Pixel_Ready), .Timer_Reload(Timer_Reload),
    .Timer_Value(Timer_Value), .Timer_Done(Timer_Done), .Dout(Dout), .Busy(Busy),
    .Underrun(Underrun), .Frame_Done(Frame_Done)
  );

  always #5 Clock = ~Clock;

  // One-shot timer: reload loads V and clears Done; Done rises V cycles later.
  logic          tdone = 1'b1;
  logic [VW-1:0] tcnt  = '0;
  assign Timer_Done = tdone;
  always @(posedge Clock) begin
    if (Timer_Reload) begin
      tcnt  <= Timer_Value;
      tdone <= 1'b0;
    end else if (tcnt == VW'(1)) begin
      tcnt  <= '0;
      tdone <= 1'b1;
    end else if (tcnt != '0) begin
      tcnt <= tcnt - VW'(1);
    end
  end

  // Observation monitor, sampled on the falling edge.
  int cyc = 0;
  int rise_q[$], fall_q[$], acc_q[$], rv_q[$];
  int rl_n = 0, rl_wide = 0, fd_n = 0, fd_cyc = 0, ur_n = 0, bf_cyc = 0;
  logic prev_dout = 1'b0, prev_rl = 1'b0, prev_busy = 1'b0;
  always @(negedge Clock) begin
    cyc <= cyc + 1;
    if (Dout && !prev_dout) rise_q.push_back(cyc);
    if (!Dout && prev_dout) fall_q.push_back(cyc);
    prev_dout <= Dout;
    if (Timer_Reload) begin
      rl_n <= rl_n + 1;
      rv_q.push_back(int'(Timer_Value));
      if (prev_rl) rl_wide <= rl_wide + 1;
    end
    prev_rl <= Timer_Reload;
    if (Frame_Done) begin
      fd_n   <= fd_n + 1;
      fd_cyc <= cyc;
    end
    if (Underrun) ur_n <= ur_n + 1;
    if (Pixel_Valid && Pixel_Ready) acc_q.push_back(cyc);
    if (!Busy && prev_busy) bf_cyc <= cyc;
    prev_busy <= Busy;
  end

  int checks = 0;
  int errors = 0;

  function automatic logic word_bit(input logic [23:0] w, input int i);
    return w[23 - i];
  endfunction

  task automatic clear_mon();
    rise_q.delete(); fall_q.delete(); acc_q.delete(); rv_q.delete();
  endtask

  task automatic send_pixel(input logic [23:0] d, input logic l);
    int n0;
    n0 = acc_q.size();
    Pixel_Data = d; Pixel_Last = l; Pixel_Valid = 1'b1;
    for (int i = 0; i < 2000 && acc_q.size() == n0; i++) begin
      @(posedge Clock); #1;
    end
    if (acc_q.size() == n0) begin
      checks++; errors++;
      $display("FAIL handshake_timeout data=%h got no accept, required accept", d);
    end
  endtask

  task automatic wait_frame(input int target);
    for (int i = 0; i < 5000 && fd_n < target; i++) begin
      @(posedge Clock); #1;
    end
    if (fd_n < target) begin
      checks++; errors++;
      $display("FAIL frame_timeout fd_count=%0d required=%0d", fd_n, target);
    end
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    cRst = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    checks++; if (Dout !== 1'b0) begin errors++; $display("FAIL reset_dout got=%b exp=0", Dout); end
    checks++; if (Timer_Reload !== 1'b0) begin errors++; $display("FAIL reset_reload got=%b exp=0", Timer_Reload); end
    checks++; if (Timer_Value !== '0) begin errors++; $display("FAIL reset_value got=%0d exp=0", Timer_Value); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Underrun !== 1'b0 || Frame_Done !== 1'b0) begin
      errors++; $display("FAIL reset_pulses ur=%b fd=%b exp=0/0", Underrun, Frame_Done);
    end
    checks++; if (Pixel_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", Pixel_Ready); end
    @(posedge Clock); #1;
    cRst = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
  endtask

  task automatic test_single_pixel();
    logic [23:0] w;
    int fd0, rl0, rw0, e, bad;
    int eseq[$];
    w = 24'hA50000;
    clear_mon(); fd0 = fd_n; rl0 = rl_n; rw0 = rl_wide;
    send_pixel(w, 1'b1);
    Pixel_Valid = 1'b0;
    wait_frame(fd0 + 1);
    checks++; if (rise_q.size() != 24 || fall_q.size() != 24) begin
      errors++; $display("FAIL single_bitcount rises=%0d falls=%0d exp=24", rise_q.size(), fall_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        e = word_bit(w, i) ? T1H : T0H;
        checks++; if (fall_q[i] - rise_q[i] != e) begin
          errors++; $display("FAIL single_high bit%0d width=%0d exp=%0d", i, fall_q[i] - rise_q[i], e);
        end
        if (i < 23) begin
          checks++; if (rise_q[i+1] - rise_q[i] != 12) begin
            errors++; $display("FAIL single_period bit%0d period=%0d exp=12", i, rise_q[i+1] - rise_q[i]);
          end
        end
      end
      checks++; if (fd_cyc - fall_q[23] != T0L + TR) begin
        errors++; $display("FAIL single_latch_gap low=%0d exp=%0d", fd_cyc - fall_q[23], T0L + TR);
      end
      checks++; if (bf_cyc != fd_cyc) begin
        errors++; $display("FAIL single_busy_fall cyc=%0d exp=%0d", bf_cyc, fd_cyc);
      end
      checks++; if (acc_q.size() < 1 || rise_q[0] - acc_q[0] != 1) begin
        errors++; $display("FAIL single_first_rise delay=%0d exp=1", acc_q.size() > 0 ? rise_q[0] - acc_q[0] : -1);
      end
    end
    checks++; if (fd_n - fd0 != 1) begin errors++; $display("FAIL single_frame_done count=%0d exp=1", fd_n - fd0); end
    checks++; if (rl_n - rl0 != 49) begin errors++; $display("FAIL single_reload_count count=%0d exp=49", rl_n - rl0); end
    checks++; if (rl_wide != rw0) begin errors++; $display("FAIL single_reload_width wide=%0d exp=0", rl_wide - rw0); end
    for (int i = 0; i < 24; i++) begin
      eseq.push_back(word_bit(w, i) ? T1H - 2 : T0H - 2);
      eseq.push_back(word_bit(w, i) ? T1L - 2 : T0L - 2);
    end
    eseq.push_back(TR - 2);
    bad = 0;
    for (int i = 0; i < eseq.size(); i++)
      if (i >= rv_q.size() || rv_q[i] != eseq[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL single_reload_values wrong=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    int fd0, rl0, ur0, e;
    clear_mon(); fd0 = fd_n; rl0 = rl_n; ur0 = ur_n;
    send_pixel(24'hFFFFFF, 1'b0);
    send_pixel(24'h000000, 1'b1);
    Pixel_Valid = 1'b0;
    wait_frame(fd0 + 1);
    checks++; if (rise_q.size() != 48 || fall_q.size() != 48 || acc_q.size() != 2) begin
      errors++; $display("FAIL b2b_bitcount rises=%0d accepts=%0d exp=48/2", rise_q.size(), acc_q.size());
    end else begin
      for (int i = 0; i < 48; i++) begin
        e = (i < 24) ? T1H : T0H;
        checks++; if (fall_q[i] - rise_q[i] != e) begin
          errors++; $display("FAIL b2b_high bit%0d width=%0d exp=%0d", i, fall_q[i] - rise_q[i], e);
        end
        if (i < 47) begin
          e = (i < 24) ? T1L : T0L;
          checks++; if (rise_q[i+1] - fall_q[i] != e) begin
            errors++; $display("FAIL b2b_low bit%0d width=%0d exp=%0d", i, rise_q[i+1] - fall_q[i], e);
          end
        end
      end
      checks++; if (rise_q[24] - acc_q[1] != 1) begin
        errors++; $display("FAIL b2b_accept_edge delay=%0d exp=1", rise_q[24] - acc_q[1]);
      end
    end
    checks++; if (fd_n - fd0 != 1) begin errors++; $display("FAIL b2b_frame_done count=%0d exp=1", fd_n - fd0); end
    checks++; if (ur_n != ur0) begin errors++; $display("FAIL b2b_underrun count=%0d exp=0", ur_n - ur0); end
    checks++; if (rl_n - rl0 != 97) begin errors++; $display("FAIL b2b_reload_count count=%0d exp=97", rl_n - rl0); end
  endtask

  task automatic test_underrun();
    int fd0, ur0, rl0, hi;
    clear_mon(); fd0 = fd_n; ur0 = ur_n; rl0 = rl_n;
    send_pixel(24'h00000F, 1'b0);
    Pixel_Valid = 1'b0;
    for (int i = 0; i < 1000 && ur_n == ur0; i++) begin
      @(posedge Clock); #1;
    end
    @(negedge Clock);
    checks++; if (Busy !== 1'b1 || Pixel_Ready !== 1'b1) begin
      errors++; $display("FAIL underrun_wait_state busy=%b ready=%b exp=1/1", Busy, Pixel_Ready);
    end
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (Dout !== 1'b0) hi++;
    end
    checks++; if (hi != 0) begin errors++; $display("FAIL underrun_dout_low high_cycles=%0d exp=0", hi); end
    @(posedge Clock); #1;
    send_pixel(24'h800001, 1'b1);
    Pixel_Valid = 1'b0;
    wait_frame(fd0 + 1);
    checks++; if (ur_n - ur0 != 1) begin errors++; $display("FAIL underrun_pulse count=%0d exp=1", ur_n - ur0); end
    checks++; if (rise_q.size() != 48 || acc_q.size() != 2) begin
      errors++; $display("FAIL underrun_bitcount rises=%0d accepts=%0d exp=48/2", rise_q.size(), acc_q.size());
    end else begin
      checks++; if (rise_q[24] - acc_q[1] != 1) begin
        errors++; $display("FAIL underrun_late_start delay=%0d exp=1", rise_q[24] - acc_q[1]);
      end
      checks++; if (rise_q[24] - fall_q[23] < T1L + 30) begin
        errors++; $display("FAIL underrun_gap low=%0d exp>=%0d", rise_q[24] - fall_q[23], T1L + 30);
      end
      checks++; if (fall_q[24] - rise_q[24] != T1H) begin
        errors++; $display("FAIL underrun_late_high width=%0d exp=%0d", fall_q[24] - rise_q[24], T1H);
      end
    end
    checks++; if (fd_n - fd0 != 1) begin errors++; $display("FAIL underrun_frame_done count=%0d exp=1", fd_n - fd0); end
    checks++; if (rl_n - rl0 != 97) begin errors++; $display("FAIL underrun_reload_count count=%0d exp=97", rl_n - rl0); end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] w;
    int fd0, hi, e;
    clear_mon(); fd0 = fd_n;
    send_pixel(24'hFFFFFF, 1'b1);
    Pixel_Valid = 1'b0;
    for (int i = 0; i < 1000 && rise_q.size() < 14; i++) begin
      @(posedge Clock); #1;
    end
    cRst = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    checks++; if (Dout !== 1'b0) begin errors++; $display("FAIL midreset_dout got=%b exp=0", Dout); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", Busy); end
    checks++; if (Pixel_Ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", Pixel_Ready); end
    @(posedge Clock); #1;
    cRst = 1'b0;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (Dout !== 1'b0) hi++;
    end
    checks++; if (hi != 0 || fd_n != fd0) begin
      errors++; $display("FAIL midreset_quiet high=%0d frame_done=%0d exp=0/0", hi, fd_n - fd0);
    end
    @(posedge Clock); #1;
    w = 24'h0F0F0F;
    clear_mon();
    send_pixel(w, 1'b1);
    Pixel_Valid = 1'b0;
    wait_frame(fd0 + 1);
    checks++; if (rise_q.size() != 24 || fall_q.size() != 24) begin
      errors++; $display("FAIL midreset_restart rises=%0d exp=24", rise_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        e = word_bit(w, i) ? T1H : T0H;
        checks++; if (fall_q[i] - rise_q[i] != e) begin
          errors++; $display("FAIL midreset_high bit%0d width=%0d exp=%0d", i, fall_q[i] - rise_q[i], e);
        end
      end
    end
    checks++; if (fd_n - fd0 != 1) begin errors++; $display("FAIL midreset_frame_done count=%0d exp=1", fd_n - fd0); end
  endtask

  task automatic test_valid_toggle();
    logic [23:0] w;
    int fd0, rdy, e;
    w = 24'hC30000;
    clear_mon(); fd0 = fd_n;
    send_pixel(w, 1'b1);
    rdy = 0;
    for (int i = 0; i < 100; i++) begin
      Pixel_Valid = 1'($urandom_range(0, 1));
      Pixel_Data  = 24'($urandom);
      @(negedge Clock);
      if (Pixel_Ready !== 1'b0) rdy++;
      @(posedge Clock); #1;
    end
    Pixel_Valid = 1'b0;
    checks++; if (rdy != 0) begin errors++; $display("FAIL toggle_ready high_cycles=%0d exp=0", rdy); end
    wait_frame(fd0 + 1);
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL toggle_accepts count=%0d exp=1", acc_q.size()); end
    checks++; if (rise_q.size() != 24 || fall_q.size() != 24) begin
      errors++; $display("FAIL toggle_bitcount rises=%0d exp=24", rise_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        e = word_bit(w, i) ? T1H : T0H;
        checks++; if (fall_q[i] - rise_q[i] != e) begin
          errors++; $display("FAIL toggle_high bit%0d width=%0d exp=%0d", i, fall_q[i] - rise_q[i], e);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    test_valid_toggle();
    checks++; if (rl_wide != 0) begin errors++; $display("FAIL reload_strobe_width wide=%0d exp=0", rl_wide); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
